// File: rtl/score_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : score_accumulator
// Purpose  : Running rhythm-game statistics (points, combo, max combo,
//            per-grade hit counts) with a serial double-dabble converter
//            that turns the point total into 4-digit BCD for the display.
// Revision : 1.0 - initial release
// ============================================================================
module score_accumulator #(
    parameter int PERFECT_PTS  = 10,
    parameter int GOOD_PTS     = 5,
    parameter int COMBO_THRESH = 10,
    parameter int MAX_SCORE    = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        delete_note,
    input  logic [1:0]  score,
    input  logic        miss,
    output logic [13:0] total,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo,
    output logic [7:0]  perfect_cnt,
    output logic [7:0]  good_cnt,
    output logic [7:0]  miss_cnt,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic        busy
);

    // Constants sized to the arithmetic they take part in.
    localparam logic [14:0] c_PERFECT_PTS  = 15'(PERFECT_PTS);
    localparam logic [14:0] c_GOOD_PTS     = 15'(GOOD_PTS);
    localparam logic [7:0]  c_COMBO_THRESH = 8'(COMBO_THRESH);
    localparam logic [14:0] c_MAX_SCORE    = 15'(MAX_SCORE);
    localparam logic [3:0]  c_LAST_SHIFT   = 4'd13;   // 14 input bits

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [13:0] total_q,     total_d;
    logic [7:0]  combo_q,     combo_d;
    logic [7:0]  max_combo_q, max_combo_d;
    logic [7:0]  perfect_q,   perfect_d;
    logic [7:0]  good_q,      good_d;
    logic [7:0]  miss_q,      miss_d;
    logic        pending_q,   pending_d;
    logic [15:0] bcd_q,       bcd_d;
    logic        bcd_valid_q, bcd_valid_d;
    state_t      state_q,     state_d;
    logic [13:0] bin_q,       bin_d;
    logic [15:0] scratch_q,   scratch_d;
    logic [3:0]  cnt_q,       cnt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_rst;
    logic        w_is_hit;
    logic        w_is_nohit;
    logic        w_is_perfect;
    logic [14:0] w_pts;
    logic [14:0] w_added;
    logic [14:0] w_sum;
    logic [13:0] w_total_next;
    logic [7:0]  w_combo_hit;
    logic [1:0]  w_miss_inc;
    logic [8:0]  w_miss_sum;
    logic        w_changed;
    logic [15:0] w_adj;

    assign w_rst = rst | clear;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Double-dabble correction: any BCD digit of 5 or more gets +3 before
    // the shift so that it carries correctly into the next digit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                    ? scratch_q[4*gi +: 4] + 4'd3
                                    : scratch_q[4*gi +: 4];
        end
    endgenerate

    // Hit / miss bookkeeping: hit applied first, then a coincident miss.
    always_comb begin
        w_is_hit     = delete_note && (score != 2'b00);
        w_is_nohit   = delete_note && (score == 2'b00);
        w_is_perfect = w_is_hit && (score == 2'b11);
        w_pts        = w_is_perfect ? c_PERFECT_PTS : c_GOOD_PTS;

        // Multiplier looks at the combo before this hit counts.
        w_added = 15'd0;
        if (w_is_hit) begin
            w_added = (combo_q >= c_COMBO_THRESH) ? (w_pts << 1) : w_pts;
        end

        w_sum        = {1'b0, total_q} + w_added;
        w_total_next = (w_sum > c_MAX_SCORE) ? c_MAX_SCORE[13:0] : w_sum[13:0];
        w_changed    = (w_total_next != total_q);

        w_combo_hit = combo_q;
        if (w_is_hit) begin
            w_combo_hit = sat_inc(combo_q);
        end else if (w_is_nohit) begin
            w_combo_hit = 8'd0;
        end

        w_miss_inc = {1'b0, w_is_nohit} + {1'b0, miss};
        w_miss_sum = {1'b0, miss_q} + {7'd0, w_miss_inc};

        total_d     = w_total_next;
        max_combo_d = (w_combo_hit > max_combo_q) ? w_combo_hit : max_combo_q;
        combo_d     = miss ? 8'd0 : w_combo_hit;
        perfect_d   = w_is_perfect ? sat_inc(perfect_q) : perfect_q;
        good_d      = (w_is_hit && !w_is_perfect) ? sat_inc(good_q) : good_q;
        miss_d      = (w_miss_sum > 9'd255) ? 8'hFF : w_miss_sum[7:0];
    end

    // Converter next-state and datapath; a total change always wins over DONE.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        bcd_valid_d = bcd_valid_q;
        pending_d   = pending_q;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    bin_d     = total_q;
                    scratch_d = 16'd0;
                    cnt_d     = 4'd0;
                    pending_d = 1'b0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scratch_d = (w_adj << 1) | {15'd0, bin_q[13]};
                bin_d     = bin_q << 1;
                if (cnt_q == c_LAST_SHIFT) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                bcd_d = scratch_q;
                if (!pending_q) begin
                    bcd_valid_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_changed) begin
            pending_d   = 1'b1;
            bcd_valid_d = 1'b0;
        end
    end

    // State register for statistics and converter; rst/clear abort everything.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            total_q     <= 14'd0;
            combo_q     <= 8'd0;
            max_combo_q <= 8'd0;
            perfect_q   <= 8'd0;
            good_q      <= 8'd0;
            miss_q      <= 8'd0;
            pending_q   <= 1'b0;
            bcd_q       <= 16'd0;
            bcd_valid_q <= 1'b1;
            state_q     <= S_IDLE;
            bin_q       <= 14'd0;
            scratch_q   <= 16'd0;
            cnt_q       <= 4'd0;
        end else begin
            total_q     <= total_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
            perfect_q   <= perfect_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            pending_q   <= pending_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            state_q     <= state_d;
            bin_q       <= bin_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
        end
    end

    assign total       = total_q;
    assign combo       = combo_q;
    assign max_combo   = max_combo_q;
    assign perfect_cnt = perfect_q;
    assign good_cnt    = good_q;
    assign miss_cnt    = miss_q;
    assign bcd         = bcd_q;
    assign bcd_valid   = bcd_valid_q;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire
